// File: rtl/smul_seq.sv
// Multi-cycle shift-add multiplier, signed/unsigned, start/busy/done handshake.
// Optional SMUL_SEQ_EARLY_EXIT_EN: stop once remaining multiplier bits are zero.
module smul_seq #(
    parameter int DATAWIDTH = 64
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     start,
    input  logic                     is_signed,
    input  logic [DATAWIDTH-1:0]     a,
    input  logic [DATAWIDTH-1:0]     b,
    output logic                     busy,
    output logic                     done,
    output logic [DATAWIDTH-1:0]     prod,
    output logic [2*DATAWIDTH-1:0]   prod_full,
    output logic                     ovf
);

    localparam int W  = DATAWIDTH;
    localparam int CW = (W > 2) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*W-1:0]   mag_a_q, mag_a_d;
    logic [W-1:0]     mag_b_q, mag_b_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic             neg_q, neg_d;
    logic             sgn_q, sgn_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [W-1:0]     prod_q, prod_d;
    logic [2*W-1:0]   prod_full_q, prod_full_d;
    logic             ovf_q, ovf_d;

    logic             a_neg;
    logic             b_neg;
    logic [W-1:0]     mag_a_in;
    logic [W-1:0]     mag_b_in;
    logic             last;
    logic [2*W-1:0]   full;
    logic [2*W-1:0]   sext;

    always_comb begin
        a_neg    = is_signed & a[W-1];
        b_neg    = is_signed & b[W-1];
        mag_a_in = a_neg ? -a : a;
        mag_b_in = b_neg ? -b : b;
`ifdef SMUL_SEQ_EARLY_EXIT_EN
        last = (cnt_q == CW'(W - 1)) || (mag_b_q[W-1:1] == '0);
`else
        last = (cnt_q == CW'(W - 1));
`endif
        full = neg_q ? -acc_q : acc_q;
        sext = {{W{full[W-1]}}, full[W-1:0]};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mag_a_d     = mag_a_q;
        mag_b_d     = mag_b_q;
        acc_d       = acc_q;
        neg_d       = neg_q;
        sgn_d       = sgn_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        prod_d      = prod_q;
        prod_full_d = prod_full_q;
        ovf_d       = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mag_a_d = {{W{1'b0}}, mag_a_in};
                    mag_b_d = mag_b_in;
                    neg_d   = a_neg ^ b_neg;
                    sgn_d   = is_signed;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (mag_b_q[0]) begin
                    acc_d = acc_q + mag_a_q;
                end
                mag_a_d = mag_a_q << 1;
                mag_b_d = mag_b_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (last) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                prod_full_d = full;
                prod_d      = full[W-1:0];
                ovf_d       = sgn_q ? (full != sext) : (full[2*W-1:W] != '0);
                done_d      = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mag_a_q     <= '0;
            mag_b_q     <= '0;
            acc_q       <= '0;
            neg_q       <= 1'b0;
            sgn_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            prod_q      <= '0;
            prod_full_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mag_a_q     <= mag_a_d;
            mag_b_q     <= mag_b_d;
            acc_q       <= acc_d;
            neg_q       <= neg_d;
            sgn_q       <= sgn_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            prod_q      <= prod_d;
            prod_full_q <= prod_full_d;
            ovf_q       <= ovf_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign prod      = prod_q;
    assign prod_full = prod_full_q;
    assign ovf       = ovf_q;

endmodule
